// File: rtl/router_pkg.sv
// Shared types and helpers for the N-input two-class QoS router.
package router_pkg;

  typedef enum logic {
    CLS_REG = 1'b0,
    CLS_PRI = 1'b1
  } cls_e;

  localparam int DATA_W_DEF    = 32;
  localparam int CLASS_BIT_DEF = 31;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/router_nx1_qos_arb.sv
// Round-robin arbiter; search starts at the pointer, which moves past the winner on advance.
module rr_arbiter
  import router_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_hit;
  int            j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_hit = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_hit && i_req[j]) begin
        w_hit    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/router_nx1_qos_fifo.sv
// Parametrised synchronous FIFO with show-ahead read and occupancy count.
module sync_fifo #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_wr,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic                 i_rd,
  output logic [DataWidth-1:0] o_rdata,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AddrWidth-1:0] r_wptr;
  logic [AddrWidth-1:0] r_rptr;
  logic [AddrWidth:0]   r_cnt;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_cnt == (AddrWidth+1)'(Depth));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_wr && !o_full;
  assign w_pop   = i_rd && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/router_nx1_qos.sv
// N-input, 1-output router with regular/priority class FIFOs and starvation guard.
module router_nx1_qos
  import router_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FIFO_AW      = 2,
  parameter int CLASS_BIT    = CLASS_BIT_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_PORTS*DATA_W-1:0] data_i,
  input  logic [NUM_PORTS-1:0]        valid_i,
  output logic [NUM_PORTS-1:0]        ready_o,
  output logic [DATA_W-1:0]           data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        starve_o
);

  localparam int PW = clog2(NUM_PORTS);
  localparam int CW = clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [NUM_PORTS-1:0] w_req_reg, w_req_pri;
  logic [NUM_PORTS-1:0] w_gnt_reg, w_gnt_pri;
  logic [PW-1:0]        w_idx_reg, w_idx_pri;
  logic                 w_adv_reg, w_adv_pri;
  logic                 w_full_reg, w_full_pri;
  logic                 w_empty_reg, w_empty_pri;
  logic [DATA_W-1:0]    w_wdata_reg, w_wdata_pri;
  logic [DATA_W-1:0]    w_rdata_reg, w_rdata_pri;
  logic                 w_load, w_force;
  cls_e                 w_src;

  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 r_starve;
  logic [CW-1:0]        r_cnt;

  always_comb begin
    w_req_reg = '0;
    w_req_pri = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_i[i*DATA_W+CLASS_BIT]) w_req_pri[i] = valid_i[i];
      else                            w_req_reg[i] = valid_i[i];
    end
  end

  assign w_adv_reg   = |w_req_reg && !w_full_reg;
  assign w_adv_pri   = |w_req_pri && !w_full_pri;
  assign w_wdata_reg = data_i[int'(w_idx_reg)*DATA_W +: DATA_W];
  assign w_wdata_pri = data_i[int'(w_idx_pri)*DATA_W +: DATA_W];
  assign ready_o     = (w_gnt_reg & {NUM_PORTS{!w_full_reg}})
                     | (w_gnt_pri & {NUM_PORTS{!w_full_pri}});

  rr_arbiter #(.N(NUM_PORTS)) u_arb_reg (
    .clk(clk), .rstn(rstn), .i_req(w_req_reg), .i_adv(w_adv_reg),
    .o_gnt(w_gnt_reg), .o_idx(w_idx_reg)
  );

  rr_arbiter #(.N(NUM_PORTS)) u_arb_pri (
    .clk(clk), .rstn(rstn), .i_req(w_req_pri), .i_adv(w_adv_pri),
    .o_gnt(w_gnt_pri), .o_idx(w_idx_pri)
  );

  sync_fifo #(.DataWidth(DATA_W), .AddrWidth(FIFO_AW)) u_fifo_reg (
    .clk(clk), .rstn(rstn), .i_wr(w_adv_reg), .i_wdata(w_wdata_reg),
    .i_rd(w_load && (w_src == CLS_REG)), .o_rdata(w_rdata_reg),
    .o_full(w_full_reg), .o_empty(w_empty_reg)
  );

  sync_fifo #(.DataWidth(DATA_W), .AddrWidth(FIFO_AW)) u_fifo_pri (
    .clk(clk), .rstn(rstn), .i_wr(w_adv_pri), .i_wdata(w_wdata_pri),
    .i_rd(w_load && (w_src == CLS_PRI)), .o_rdata(w_rdata_pri),
    .o_full(w_full_pri), .o_empty(w_empty_pri)
  );

  assign w_load  = (!r_valid || ready_i) && !(w_empty_reg && w_empty_pri);
  assign w_force = !w_empty_reg && (r_cnt == LIM);
  assign w_src   = (w_force || w_empty_pri) ? CLS_REG : CLS_PRI;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_starve <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_data   <= (w_src == CLS_REG) ? w_rdata_reg : w_rdata_pri;
      r_valid  <= 1'b1;
      r_starve <= w_force;
      if (w_src == CLS_PRI && !w_empty_reg) begin
        if (r_cnt != LIM) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end else begin
      r_starve <= 1'b0;
      if (ready_i) r_valid <= 1'b0;
    end
  end

  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign starve_o = r_starve;

endmodule
